fpga_clkdiv_bank: RTL and testbench

FPGA_CLKDIV_BANK -- requirements
Module: fpga_clkdiv_bank

---
 rtl/fpga_clkdiv_bank_if.sv | 25 ++
 rtl/fpga_clkdiv_bank.sv | 118 +++++++++++
 tb/tb_fpga_clkdiv_bank.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_clkdiv_bank_if.sv
// Configuration and status bundle for fpga_clkdiv_bank.
// The master drives the divider configuration and enables; the slave returns the divided clocks and status.
interface fpga_clkdiv_bank_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 26
);
    logic              cfg_we_i;
    logic [2:0]        cfg_ch_i;
    logic [CNT_W-1:0]  cfg_div_i;
    logic [NUM_CH-1:0] ch_en_i;
    logic [NUM_CH-1:0] div_clk_o;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] busy_o;
    logic              hb_o;

    modport master (
        output cfg_we_i, cfg_ch_i, cfg_div_i, ch_en_i,
        input  div_clk_o, tick_o, busy_o, hb_o
    );

    modport slave (
        input  cfg_we_i, cfg_ch_i, cfg_div_i, ch_en_i,
        output div_clk_o, tick_o, busy_o, hb_o
    );
endinterface

// File: rtl/fpga_clkdiv_bank.sv
// Bank of independent 50%-duty clock dividers with glitch-free reload and stop.
// An optional LED heartbeat is built when CLKDIV_HB_EN is defined; otherwise hb_o is tied low.
module fpga_clkdiv_bank #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 4,
    parameter int unsigned HB_HALF     = 25000000
) (
    input logic                clk,
    input logic                rst_n,
    fpga_clkdiv_bank_if.slave  io_bus
);

    if (NUM_CH < 1 || NUM_CH > 8 || HB_HALF < 1) begin : g_bad_param
        $error("fpga_clkdiv_bank: NUM_CH must be 1..8 and HB_HALF at least 1");
    end

    logic [NUM_CH-1:0] w_div_clk;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_busy;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_cnt, r_div_q, r_div_p;
        logic [CNT_W-1:0] w_cnt_nx, w_div_q_nx, w_div_p_nx;
        logic             r_pend, r_clk, r_tick;
        logic             w_pend_nx, w_clk_nx, w_tick_nx;
        logic             w_active, w_tc, w_wr;

        // A channel keeps running while enabled or while it drains its high half-period.
        assign w_active = io_bus.ch_en_i[gi] | r_clk;
        assign w_tc     = w_active && (r_cnt == r_div_q);
        assign w_wr     = io_bus.cfg_we_i && (io_bus.cfg_ch_i == 3'(gi));

        always_comb begin
            w_cnt_nx   = r_cnt;
            w_div_q_nx = r_div_q;
            w_div_p_nx = r_div_p;
            w_pend_nx  = r_pend;
            w_clk_nx   = r_clk;
            w_tick_nx  = 1'b0;

            if (w_active) begin
                if (w_tc) begin
                    w_cnt_nx  = '0;
                    w_clk_nx  = ~r_clk;
                    w_tick_nx = 1'b1;
                    if (r_pend) begin
                        w_div_q_nx = r_div_p;
                        w_pend_nx  = 1'b0;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end else begin
                w_cnt_nx = '0;
                if (r_pend) begin
                    w_div_q_nx = r_div_p;
                    w_pend_nx  = 1'b0;
                end
            end

            // A write landing on the reload edge stays pending for the next boundary.
            if (w_wr) begin
                w_div_p_nx = io_bus.cfg_div_i;
                w_pend_nx  = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_div_q <= CNT_W'(DEFAULT_DIV);
                r_div_p <= '0;
                r_pend  <= 1'b0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nx;
                r_div_q <= w_div_q_nx;
                r_div_p <= w_div_p_nx;
                r_pend  <= w_pend_nx;
                r_clk   <= w_clk_nx;
                r_tick  <= w_tick_nx;
            end
        end

        assign w_div_clk[gi] = r_clk;
        assign w_tick[gi]    = r_tick;
        assign w_busy[gi]    = r_pend | (~io_bus.ch_en_i[gi] & r_clk);
    end

    assign io_bus.div_clk_o = w_div_clk;
    assign io_bus.tick_o    = w_tick;
    assign io_bus.busy_o    = w_busy;

`ifdef CLKDIV_HB_EN
    localparam int unsigned HB_W = $clog2(2 * HB_HALF);

    logic [HB_W-1:0] r_hb_cnt;
    logic            r_hb;

    // Free-running heartbeat: high for the first half of each 2*HB_HALF window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else begin
            r_hb     <= (r_hb_cnt < HB_W'(HB_HALF));
            r_hb_cnt <= (r_hb_cnt == HB_W'(2 * HB_HALF - 1)) ? '0 : r_hb_cnt + HB_W'(1);
        end
    end

    assign io_bus.hb_o = r_hb;
`else
    assign io_bus.hb_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_clkdiv_bank.sv
// Self-checking bench for fpga_clkdiv_bank: directed table, corner sequences and random traffic
// compared against a countdown-based behavioural model of each channel.
module tb_fpga_clkdiv_bank;

    localparam int unsigned NCH  = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned DDIV = 4;
    localparam int unsigned HBH  = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    fpga_clkdiv_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) u_if ();

    fpga_clkdiv_bank #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV),
        .HB_HALF     (HBH)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: cycles remaining until the next toggle, per channel.
    logic [NCH-1:0] m_lvl, m_tick, m_pend;
    int             m_rem  [NCH];
    int             m_div  [NCH];
    int             m_pval [NCH];
    int             m_edges;

    typedef struct {
        logic           we;
        logic [2:0]     ch;
        logic [CW-1:0]  dv;
        logic [NCH-1:0] en;
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_tick;
        logic [NCH-1:0] e_busy;
    } vec_t;

    vec_t tbl [20];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl   = '0;
        m_tick  = '0;
        m_pend  = '0;
        m_edges = 0;
        for (int c = 0; c < NCH; c++) begin
            m_div[c]  = DDIV;
            m_pval[c] = 0;
            m_rem[c]  = DDIV + 1;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 1'b0;
            if (u_if.ch_en_i[c] || m_lvl[c]) begin
                if (m_rem[c] == 1) begin
                    m_lvl[c]  = ~m_lvl[c];
                    m_tick[c] = 1'b1;
                    if (m_pend[c]) begin
                        m_div[c]  = m_pval[c];
                        m_pend[c] = 1'b0;
                    end
                    m_rem[c] = m_div[c] + 1;
                end else begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end else begin
                if (m_pend[c]) begin
                    m_div[c]  = m_pval[c];
                    m_pend[c] = 1'b0;
                end
                m_rem[c] = m_div[c] + 1;
            end
            if (u_if.cfg_we_i && (u_if.cfg_ch_i == 3'(c))) begin
                m_pval[c] = int'(u_if.cfg_div_i);
                m_pend[c] = 1'b1;
            end
        end
        m_edges++;
    endtask

    task automatic check_model();
        logic hb_e;
`ifdef CLKDIV_HB_EN
        hb_e = (m_edges > 0) && (((m_edges - 1) % (2 * HBH)) < HBH);
`else
        hb_e = 1'b0;
`endif
        cmp("model_div_clk", 32'(u_if.div_clk_o), 32'(m_lvl));
        cmp("model_tick",    32'(u_if.tick_o),    32'(m_tick));
        cmp("model_busy",    32'(u_if.busy_o),    32'(m_pend | (~u_if.ch_en_i & m_lvl)));
        cmp("model_hb",      32'(u_if.hb_o),      32'(hb_e));
    endtask

    // One clock: advance the model at the rising edge, check on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        u_if.cfg_we_i  = 1'b0;
        u_if.ch_en_i   = '0;
        #1;
        cmp("rst_div_clk", 32'(u_if.div_clk_o), 32'd0);
        cmp("rst_tick",    32'(u_if.tick_o),    32'd0);
        cmp("rst_busy",    32'(u_if.busy_o),    32'd0);
        cmp("rst_hb",      32'(u_if.hb_o),      32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!u_if.tick_o[ch] && n < 64);
        if (!u_if.tick_o[ch]) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_tick ch%0d: no tick within %0d cycles", ch, n);
        end
    endtask

    task automatic row(input int i, input logic we, input logic [2:0] ch, input logic [CW-1:0] dv,
                       input logic [1:0] ec, input logic [1:0] et, input logic [1:0] eb);
        tbl[i] = '{we, ch, dv, 2'b11, ec, et, eb};
    endtask

    initial begin
        int n;
        n_vec          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        u_if.cfg_we_i  = 1'b0;
        u_if.cfg_ch_i  = '0;
        u_if.cfg_div_i = '0;
        u_if.ch_en_i   = '0;
        model_reset();

        // Rows: default divide on both, ignored write to ch5, then ch0 reprogrammed to 1.
        for (int i = 0; i < 4; i++) row(i, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        row(4, 1'b0, 3'd0, 8'd0, 2'b11, 2'b11, 2'b00);
        for (int i = 5; i < 9; i++) row(i, 1'b0, 3'd0, 8'd0, 2'b11, 2'b00, 2'b00);
        row(9,  1'b0, 3'd0, 8'd0, 2'b00, 2'b11, 2'b00);
        row(10, 1'b1, 3'd5, 8'd1, 2'b00, 2'b00, 2'b00);
        row(11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b00);
        row(12, 1'b1, 3'd0, 8'd1, 2'b00, 2'b00, 2'b01);
        row(13, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00, 2'b01);
        row(14, 1'b0, 3'd0, 8'd0, 2'b11, 2'b11, 2'b00);
        row(15, 1'b0, 3'd0, 8'd0, 2'b11, 2'b00, 2'b00);
        row(16, 1'b0, 3'd0, 8'd0, 2'b10, 2'b01, 2'b00);
        row(17, 1'b0, 3'd0, 8'd0, 2'b10, 2'b00, 2'b00);
        row(18, 1'b0, 3'd0, 8'd0, 2'b11, 2'b01, 2'b00);
        row(19, 1'b0, 3'd0, 8'd0, 2'b01, 2'b10, 2'b00);

        do_reset();
        for (int k = 0; k < 20; k++) begin
            u_if.cfg_we_i  = tbl[k].we;
            u_if.cfg_ch_i  = tbl[k].ch;
            u_if.cfg_div_i = tbl[k].dv;
            u_if.ch_en_i   = tbl[k].en;
            cyc();
            cmp($sformatf("tbl%0d_clk", k),  32'(u_if.div_clk_o), 32'(tbl[k].e_clk));
            cmp($sformatf("tbl%0d_tick", k), 32'(u_if.tick_o),    32'(tbl[k].e_tick));
            cmp($sformatf("tbl%0d_busy", k), 32'(u_if.busy_o),    32'(tbl[k].e_busy));
        end
        u_if.cfg_we_i = 1'b0;

        // Write ch1 on its terminal-count edge, overwrite one cycle later.
        n = 0;
        while (m_rem[1] != 1 && n < 64) begin
            cyc();
            n++;
        end
        u_if.cfg_we_i  = 1'b1;
        u_if.cfg_ch_i  = 3'd1;
        u_if.cfg_div_i = 8'd2;
        cyc();
        cmp("tc_write_tick", 32'(u_if.tick_o[1]), 32'd1);
        u_if.cfg_div_i = 8'd7;
        cyc();
        u_if.cfg_we_i = 1'b0;
        cmp("tc_write_busy", 32'(u_if.busy_o[1]), 32'd1);
        wait_tick(1, n);
        cmp("ch1_half_keep4", 32'(n), 32'd4);
        wait_tick(1, n);
        cmp("ch1_half_new7a", 32'(n), 32'd8);
        wait_tick(1, n);
        cmp("ch1_half_new7b", 32'(n), 32'd8);

        // Asynchronous reset while ch0 is high.
        n = 0;
        while (!(u_if.tick_o[0] && u_if.div_clk_o[0]) && n < 64) begin
            cyc();
            n++;
        end
        do_reset();
        u_if.ch_en_i = 2'b11;
        wait_tick(0, n);
        cmp("first_rise", 32'(n), 32'd5);

        // Drop enable two cycles into the high phase: the high half must complete.
        cyc();
        cyc();
        u_if.ch_en_i = 2'b10;
        #1;
        cmp("drain_busy", 32'(u_if.busy_o[0]), 32'd1);
        wait_tick(0, n);
        cmp("drain_tail", 32'(n), 32'd3);
        cmp("drain_low",  32'(u_if.div_clk_o[0]), 32'd0);
        for (int i = 0; i < 10; i++) cyc();
        cmp("stopped_low",  32'(u_if.div_clk_o[0]), 32'd0);
        cmp("stopped_idle", 32'(u_if.busy_o[0]), 32'd0);

        // A write while stopped applies on the next edge; div 0 gives clk/2.
        u_if.cfg_we_i  = 1'b1;
        u_if.cfg_ch_i  = 3'd0;
        u_if.cfg_div_i = 8'd0;
        cyc();
        u_if.cfg_we_i = 1'b0;
        cmp("stop_pend_busy", 32'(u_if.busy_o[0]), 32'd1);
        cyc();
        cmp("stop_applied", 32'(u_if.busy_o[0]), 32'd0);
        u_if.ch_en_i = 2'b11;
        wait_tick(0, n);
        cmp("div0_first_rise", 32'(n), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            cmp("div0_tick", 32'(u_if.tick_o[0]), 32'd1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            u_if.cfg_we_i  = ($urandom_range(0, 7) == 0);
            u_if.cfg_ch_i  = 3'($urandom_range(0, 7));
            u_if.cfg_div_i = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) begin
                u_if.ch_en_i[$urandom_range(0, 1)] ^= 1'b1;
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                u_if.ch_en_i = 2'($urandom_range(0, 3));
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
